// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// and feeds decode through a one-entry IF/ID buffer backed by a skid slot.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HLT_OPC  = 4'b1111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {
        BUSY,
        HOLD,
        HALT
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] redir_pc;
    logic        squash;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;

    logic        can_load;
    logic [15:0] pc_next;
    logic [15:0] skid_pc_next;
    logic        data_hlt;
    logic        skid_hlt;

    assign imem_addr    = pc;
    assign can_load     = !stall || !if_valid;
    assign pc_next      = pc + 16'd2;
    assign skid_pc_next = skid_pc + 16'd2;
    assign data_hlt     = (imem_data[15:12] == HLT_OPC);
    assign skid_hlt     = (skid_instr[15:12] == HLT_OPC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BUSY;
            pc          <= RESET_PC;
            redir_pc    <= 16'h0000;
            squash      <= 1'b0;
            skid_instr  <= 16'h0000;
            skid_pc     <= 16'h0000;
            imem_req    <= 1'b0;
            if_valid    <= 1'b0;
            if_instr    <= 16'h0000;
            if_pc       <= 16'h0000;
            if_pc_plus2 <= 16'h0000;
            halted      <= 1'b0;
        end else begin
            if (!stall) begin
                if_valid <= 1'b0;
            end
            if (redirect) begin
                if_valid <= 1'b0;
                halted   <= 1'b0;
                state    <= BUSY;
                imem_req <= 1'b1;
                // An issued request cannot be withdrawn: park the target
                // and throw away whatever comes back for the old address.
                if (state == BUSY && imem_req && !imem_ack) begin
                    squash   <= 1'b1;
                    redir_pc <= redirect_pc;
                end else begin
                    pc     <= redirect_pc;
                    squash <= 1'b0;
                end
            end else begin
                unique case (state)
                    BUSY: begin
                        imem_req <= 1'b1;
                        if (imem_ack) begin
                            if (squash) begin
                                pc     <= redir_pc;
                                squash <= 1'b0;
                            end else if (can_load) begin
                                if_valid    <= 1'b1;
                                if_instr    <= imem_data;
                                if_pc       <= pc;
                                if_pc_plus2 <= pc_next;
                                pc          <= pc_next;
                                if (data_hlt) begin
                                    state    <= HALT;
                                    halted   <= 1'b1;
                                    imem_req <= 1'b0;
                                end
                            end else begin
                                skid_instr <= imem_data;
                                skid_pc    <= pc;
                                pc         <= pc_next;
                                state      <= HOLD;
                                imem_req   <= 1'b0;
                            end
                        end
                    end
                    HOLD: begin
                        if (can_load) begin
                            if_valid    <= 1'b1;
                            if_instr    <= skid_instr;
                            if_pc       <= skid_pc;
                            if_pc_plus2 <= skid_pc_next;
                            if (skid_hlt) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                state    <= BUSY;
                                imem_req <= 1'b1;
                            end
                        end
                    end
                    HALT: begin
                        imem_req <= 1'b0;
                    end
                    default: begin
                        state <= BUSY;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory model.
// Memory returns 16'h1000+addr, or 16'hF000 at hlt_addr.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        halted;

    int          n_checks = 0;
    int          n_fail = 0;
    int          lat = 1;
    int          cnt = 0;
    logic [15:0] hlt_addr = 16'hFFFF;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == hlt_addr) return 16'hF000;
        return 16'h1000 + a;
    endfunction

    // A consumed ack ends the request; any req after it is a new one.
    always @(posedge clk) begin
        #1;
        if (rst || !imem_req) begin
            imem_ack = 1'b0;
            cnt = 0;
        end else begin
            if (imem_ack) begin
                imem_ack = 1'b0;
                cnt = 0;
            end
            cnt = cnt + 1;
            if (cnt >= lat) begin
                imem_ack = 1'b1;
                imem_data = mem_word(imem_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (imem_ack) break;
            tick();
        end
        check(tag, {15'd0, imem_ack}, 16'd1);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        tick();
        tick();
        check("rst_req", {15'd0, imem_req}, 16'd0);
        check("rst_valid", {15'd0, if_valid}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_pc", if_pc, 16'h0000);
        check("rst_instr", if_instr, 16'h0000);
        check("rst_plus2", if_pc_plus2, 16'h0000);
        check("rst_addr", imem_addr, 16'h0000);
        rst = 1'b0;

        tick();
        check("t1_req0", {15'd0, imem_req}, 16'd1);
        check("t1_addr0", imem_addr, 16'h0000);
        check("t1_valid0", {15'd0, if_valid}, 16'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_valid", {15'd0, if_valid}, 16'd1);
            check("t1_pc", if_pc, 16'(2 * k));
            check("t1_instr", if_instr, 16'(16'h1000 + 2 * k));
            check("t1_plus2", if_pc_plus2, 16'(2 * k + 2));
            check("t1_req", {15'd0, imem_req}, 16'd1);
        end

        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t2_hold_valid", {15'd0, if_valid}, 16'd1);
            check("t2_hold_pc", if_pc, 16'h0006);
            check("t2_req_low", {15'd0, imem_req}, 16'd0);
        end
        stall = 1'b0;
        tick();
        check("t2_skid_valid", {15'd0, if_valid}, 16'd1);
        check("t2_skid_pc", if_pc, 16'h0008);
        check("t2_skid_instr", if_instr, 16'h1008);
        check("t2_req_back", {15'd0, imem_req}, 16'd1);
        check("t2_addr", imem_addr, 16'h000A);
        tick();
        check("t2_next_pc", if_pc, 16'h000A);
        check("t2_next_instr", if_instr, 16'h100A);

        lat = 3;
        tick();
        check("t3_pre_pc", if_pc, 16'h000C);
        check("t3_pre_ack", {15'd0, imem_ack}, 16'd0);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        check("t3_flush", {15'd0, if_valid}, 16'd0);
        check("t3_addr_old", imem_addr, 16'h000E);
        check("t3_req", {15'd0, imem_req}, 16'd1);
        tick();
        check("t3_flush2", {15'd0, if_valid}, 16'd0);
        tick();
        check("t3_squashed", {15'd0, if_valid}, 16'd0);
        check("t3_addr_new", imem_addr, 16'h0040);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if_valid) break;
        end
        check("t3_first_valid", {15'd0, if_valid}, 16'd1);
        check("t3_first_pc", if_pc, 16'h0040);
        check("t3_first_instr", if_instr, 16'h1040);
        lat = 1;

        wait_ack("t4_ack_seen");
        redirect = 1'b1;
        redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0;
        check("t4_flush", {15'd0, if_valid}, 16'd0);
        check("t4_addr", imem_addr, 16'h0080);
        check("t4_req", {15'd0, imem_req}, 16'd1);
        tick();
        check("t4_valid", {15'd0, if_valid}, 16'd1);
        check("t4_pc", if_pc, 16'h0080);
        check("t4_instr", if_instr, 16'h1080);

        hlt_addr = 16'h0006;
        wait_ack("t5_ack_seen");
        redirect = 1'b1;
        redirect_pc = 16'h0004;
        tick();
        redirect = 1'b0;
        check("t5_addr", imem_addr, 16'h0004);
        tick();
        check("t5_pc4", if_pc, 16'h0004);
        check("t5_not_halted", {15'd0, halted}, 16'd0);
        tick();
        check("t5_hlt_valid", {15'd0, if_valid}, 16'd1);
        check("t5_hlt_pc", if_pc, 16'h0006);
        check("t5_hlt_instr", if_instr, 16'hF000);
        check("t5_halted", {15'd0, halted}, 16'd1);
        check("t5_req_low", {15'd0, imem_req}, 16'd0);
        tick();
        check("t5_drain", {15'd0, if_valid}, 16'd0);
        check("t5_still_halted", {15'd0, halted}, 16'd1);
        tick();
        check("t5_req_still_low", {15'd0, imem_req}, 16'd0);
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        tick();
        redirect = 1'b0;
        check("t5_resume_halted", {15'd0, halted}, 16'd0);
        check("t5_resume_req", {15'd0, imem_req}, 16'd1);
        check("t5_resume_addr", imem_addr, 16'h0010);
        tick();
        check("t5_resume_valid", {15'd0, if_valid}, 16'd1);
        check("t5_resume_pc", if_pc, 16'h0010);

        wait_ack("t6_ack_seen");
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        check("t6_addr", imem_addr, 16'hFFFE);
        check("t6_flush", {15'd0, if_valid}, 16'd0);
        tick();
        check("t6_pc", if_pc, 16'hFFFE);
        check("t6_instr", if_instr, 16'h0FFE);
        check("t6_plus2_wrap", if_pc_plus2, 16'h0000);
        check("t6_addr_wrap", imem_addr, 16'h0000);
        tick();
        check("t6_pc0", if_pc, 16'h0000);
        check("t6_instr0", if_instr, 16'h1000);
        check("t6_plus2", if_pc_plus2, 16'h0002);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
